// File: rtl/bubble_sort_ctrl_if.sv
// Bundle of command, status, RAM and ALU signals between the bubble-sort sequencer
// and its surroundings; master is the sequencer, slave is the RAM/ALU/command side.
interface bubble_sort_ctrl_if #(
   parameter int AW = 3,
   parameter int DW = 16
);
   logic          start;
   logic          busy;
   logic          done;
   logic [15:0]   swap_count;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic [DW-1:0] alu_op1;
   logic [DW-1:0] alu_op2;
   logic [1:0]    alu_op;
   logic          alu_gt;

   modport master (
      input  start, mem_rdata, alu_gt,
      output busy, done, swap_count, mem_addr, mem_we, mem_wdata,
             alu_op1, alu_op2, alu_op
   );

   modport slave (
      output start, mem_rdata, alu_gt,
      input  busy, done, swap_count, mem_addr, mem_we, mem_wdata,
             alu_op1, alu_op2, alu_op
   );
endinterface

// File: rtl/bubble_sort_ctrl.sv
// In-place ascending unsigned bubble sort of RAM[0..N-1], driving a single-port
// synchronous RAM and a compare-mode ALU; early exit on a pass without swaps.
module bubble_sort_ctrl #(
   parameter int N  = 8,
   parameter int AW = 3,
   parameter int DW = 16
) (
   input  logic               clk,
   input  logic               rst,
   bubble_sort_ctrl_if.master bus
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_RD_A,
      S_RD_B,
      S_LD_B,
      S_CMP,
      S_WR_A,
      S_WR_B,
      S_NEXT,
      S_DONE
   } state_t;

   localparam int LAST = N - 2;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   state_t        r_state;
   state_t        w_state_nx;
   logic [AW-1:0] r_i;
   logic [AW-1:0] r_j;
   logic [AW-1:0] w_i_nx;
   logic [AW-1:0] w_j_nx;
   logic          r_swapped;
   logic          w_swapped_nx;
   logic [DW-1:0] r_a;
   logic [DW-1:0] r_b;
   logic [DW-1:0] w_a_nx;
   logic [DW-1:0] w_b_nx;
   logic [15:0]   r_swap_count;
   logic [15:0]   w_swap_count_nx;
   logic [AW-1:0] r_addr_hold;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] r_wdata_hold;
   logic [DW-1:0] w_wdata;
   logic          w_we;
   logic [1:0]    w_alu_op;
   logic          w_more_pairs;
   logic          w_last_pass;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_i          <= '0;
         r_j          <= '0;
         r_swapped    <= 1'b0;
         r_a          <= '0;
         r_b          <= '0;
         r_swap_count <= '0;
         r_addr_hold  <= '0;
         r_wdata_hold <= '0;
      end else begin
         r_state      <= w_state_nx;
         r_i          <= w_i_nx;
         r_j          <= w_j_nx;
         r_swapped    <= w_swapped_nx;
         r_a          <= w_a_nx;
         r_b          <= w_b_nx;
         r_swap_count <= w_swap_count_nx;
         r_addr_hold  <= w_addr;
         r_wdata_hold <= w_wdata;
      end
   end

   // Pair (j, j+1) is the last of pass i when j reaches N-2-i.
   assign w_more_pairs = (int'(r_j) + int'(r_i)) < LAST;
   assign w_last_pass  = int'(r_i) == LAST;

   always_comb begin
      w_state_nx      = r_state;
      w_i_nx          = r_i;
      w_j_nx          = r_j;
      w_swapped_nx    = r_swapped;
      w_a_nx          = r_a;
      w_b_nx          = r_b;
      w_swap_count_nx = r_swap_count;
      w_addr          = r_addr_hold;
      w_wdata         = r_wdata_hold;
      w_we            = 1'b0;
      w_alu_op        = 2'b00;

      unique case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_swap_count_nx = '0;
               w_i_nx          = '0;
               w_j_nx          = '0;
               w_swapped_nx    = 1'b0;
               w_state_nx      = (N < 2) ? S_DONE : S_RD_A;
            end
         end
         S_RD_A: begin
            w_addr     = r_j;
            w_state_nx = S_RD_B;
         end
         S_RD_B: begin
            w_addr     = r_j + AW'(1);
            w_a_nx     = bus.mem_rdata;
            w_state_nx = S_LD_B;
         end
         S_LD_B: begin
            w_b_nx     = bus.mem_rdata;
            w_state_nx = S_CMP;
         end
         S_CMP: begin
            w_alu_op   = 2'b01;
            w_state_nx = bus.alu_gt ? S_WR_A : S_NEXT;
         end
         S_WR_A: begin
            w_we       = 1'b1;
            w_addr     = r_j;
            w_wdata    = r_b;
            w_state_nx = S_WR_B;
         end
         S_WR_B: begin
            w_we            = 1'b1;
            w_addr          = r_j + AW'(1);
            w_wdata         = r_a;
            w_swap_count_nx = sat_inc16(r_swap_count);
            w_swapped_nx    = 1'b1;
            w_state_nx      = S_NEXT;
         end
         S_NEXT: begin
            if (w_more_pairs) begin
               w_j_nx     = r_j + AW'(1);
               w_state_nx = S_RD_A;
            end else if (!r_swapped || w_last_pass) begin
               w_state_nx = S_DONE;
            end else begin
               w_i_nx       = r_i + AW'(1);
               w_j_nx       = '0;
               w_swapped_nx = 1'b0;
               w_state_nx   = S_RD_A;
            end
         end
         S_DONE: begin
            w_state_nx = S_IDLE;
         end
         default: begin
            w_state_nx = S_IDLE;
         end
      endcase
   end

   assign bus.busy       = (r_state != S_IDLE) && (r_state != S_DONE);
   assign bus.done       = (r_state == S_DONE);
   assign bus.swap_count = r_swap_count;
   assign bus.mem_addr   = w_addr;
   assign bus.mem_we     = w_we;
   assign bus.mem_wdata  = w_wdata;
   assign bus.alu_op1    = r_a;
   assign bus.alu_op2    = r_b;
   assign bus.alu_op     = w_alu_op;

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Scoreboard bench for bubble_sort_ctrl: an N=8 instance on a behavioural RAM/ALU
// and an N=1 instance for the degenerate build.
module tb_bubble_sort_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bubble_sort_ctrl_if #(.AW(3), .DW(16)) bus ();
   bubble_sort_ctrl_if #(.AW(1), .DW(16)) bus1 ();

   bubble_sort_ctrl #(.N(8), .AW(3), .DW(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
   bubble_sort_ctrl #(.N(1), .AW(1), .DW(16)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   logic [15:0]      ram [0:7];
   logic             load_en = 1'b0;
   logic [7:0][15:0] load_img = '0;

   always @(posedge clk) begin
      if (load_en) begin
         for (int k = 0; k < 8; k++) ram[k] <= load_img[k];
      end else if (bus.mem_we) begin
         ram[bus.mem_addr] <= bus.mem_wdata;
      end
      bus.mem_rdata <= ram[bus.mem_addr];
   end

   assign bus.alu_gt   = bus.alu_op1 > bus.alu_op2;
   assign bus1.alu_gt  = bus1.alu_op1 > bus1.alu_op2;
   assign bus1.mem_rdata = '0;

   typedef struct {
      logic [15:0]      swaps;
      int               busy;
      int               cmps;
      logic [7:0][15:0] img;
   } exp_t;

   exp_t q[$];
   exp_t e;

   int n_chk = 0;
   int n_err = 0;
   int n_done = 0;
   int busy_cnt = 0;
   int we_cnt = 0;
   int cmp_cnt = 0;
   logic prev_done = 1'b0;
   int busy1_cnt = 0;
   int we1_cnt = 0;
   logic [7:0][15:0] img_now;

   function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   function automatic logic [7:0][15:0] mk(input logic [15:0] a0, a1, a2, a3, a4, a5, a6, a7);
      return {a7, a6, a5, a4, a3, a2, a1, a0};
   endfunction

   // Monitor: accumulates per-sort activity and scores each done pulse.
   always @(negedge clk) begin
      if (bus1.busy) busy1_cnt++;
      if (bus1.mem_we) we1_cnt++;
      if (rst) begin
         busy_cnt  = 0;
         we_cnt    = 0;
         cmp_cnt   = 0;
         prev_done = 1'b0;
      end else begin
         if (bus.busy) busy_cnt++;
         if (bus.mem_we) we_cnt++;
         if (bus.alu_op == 2'b01) cmp_cnt++;
         if (bus.done) begin
            n_done++;
            chk("done_single_cycle", 128'(prev_done), 128'(0));
            if (q.size() == 0) begin
               chk("unexpected_done", 128'(1), 128'(0));
            end else begin
               e = q.pop_front();
               for (int k = 0; k < 8; k++) img_now[k] = ram[k];
               chk("swap_count", 128'(bus.swap_count), 128'(e.swaps));
               chk("busy_cycles", 128'(busy_cnt), 128'(e.busy));
               chk("compares", 128'(cmp_cnt), 128'(e.cmps));
               chk("ram_writes", 128'(we_cnt), 128'(2 * int'(e.swaps)));
               chk("ram_image", img_now, e.img);
            end
            busy_cnt = 0;
            we_cnt   = 0;
            cmp_cnt  = 0;
         end
         prev_done = bus.done;
      end
   end

   task automatic load(input logic [7:0][15:0] img);
      load_img = img;
      load_en  = 1'b1;
      @(negedge clk);
      load_en  = 1'b0;
   endtask

   task automatic expect_sort(input logic [15:0] sw, input int by, input int cm, input logic [7:0][15:0] img);
      exp_t x;
      x.swaps = sw;
      x.busy  = by;
      x.cmps  = cm;
      x.img   = img;
      q.push_back(x);
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int d0;
      d0 = n_done;
      for (int c = 0; c < budget && n_done == d0; c++) @(negedge clk);
      chk("done_seen", 128'(n_done != d0), 128'(1));
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int d0;
      rst        = 1'b1;
      bus.start  = 1'b0;
      bus1.start = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 128'(bus.busy), 128'(0));
      chk("rst_done", 128'(bus.done), 128'(0));
      chk("rst_swap_count", 128'(bus.swap_count), 128'(0));
      chk("rst_mem_we", 128'(bus.mem_we), 128'(0));
      chk("rst_mem_addr", 128'(bus.mem_addr), 128'(0));
      chk("rst_mem_wdata", 128'(bus.mem_wdata), 128'(0));
      chk("rst_alu_op", 128'(bus.alu_op), 128'(0));
      chk("rst_alu_ops", {bus.alu_op1, bus.alu_op2}, 128'(0));
      chk("rst_n1_busy", 128'(bus1.busy), 128'(0));
      rst = 1'b0;
      @(negedge clk);

      // Already sorted: one clean pass.
      load(mk(1, 2, 3, 4, 5, 6, 7, 8));
      expect_sort(16'd0, 35, 7, mk(1, 2, 3, 4, 5, 6, 7, 8));
      pulse_start();
      wait_done(400);

      // Reverse order: every pair swaps, all seven passes.
      load(mk(8, 7, 6, 5, 4, 3, 2, 1));
      expect_sort(16'd28, 196, 28, mk(1, 2, 3, 4, 5, 6, 7, 8));
      pulse_start();
      wait_done(400);

      // Duplicates and extremes: 12 strict inversions, 5 passes of 7+6+5+4+3 compares.
      load(mk(16'hFFFF, 0, 5, 5, 0, 16'hFFFF, 1, 5));
      expect_sort(16'd12, 149, 25, mk(0, 0, 1, 5, 5, 5, 16'hFFFF, 16'hFFFF));
      pulse_start();
      wait_done(400);

      // Start pulsed mid-sort must be ignored.
      load(mk(8, 7, 6, 5, 4, 3, 2, 1));
      expect_sort(16'd28, 196, 28, mk(1, 2, 3, 4, 5, 6, 7, 8));
      d0 = n_done;
      pulse_start();
      repeat (20) @(negedge clk);
      pulse_start();
      wait_done(400);
      repeat (10) @(negedge clk);
      chk("single_done", 128'(n_done - d0), 128'(1));

      // Reset after the third swap, then resort the partially sorted RAM.
      load(mk(8, 7, 6, 5, 4, 3, 2, 1));
      pulse_start();
      for (int c = 0; c < 400 && bus.swap_count != 16'd3; c++) @(negedge clk);
      chk("swap3_reached", 128'(bus.swap_count), 128'(3));
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_busy", 128'(bus.busy), 128'(0));
      chk("midrst_done", 128'(bus.done), 128'(0));
      chk("midrst_swap_count", 128'(bus.swap_count), 128'(0));
      chk("midrst_mem_we", 128'(bus.mem_we), 128'(0));
      for (int k = 0; k < 8; k++) img_now[k] = ram[k];
      chk("midrst_ram", img_now, mk(7, 6, 5, 8, 4, 3, 2, 1));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      expect_sort(16'd25, 190, 28, mk(1, 2, 3, 4, 5, 6, 7, 8));
      pulse_start();
      wait_done(400);

      // N=1 build: straight to DONE, no activity.
      bus1.start = 1'b1;
      @(negedge clk);
      bus1.start = 1'b0;
      chk("n1_done", 128'(bus1.done), 128'(1));
      chk("n1_busy", 128'(bus1.busy), 128'(0));
      @(negedge clk);
      chk("n1_done_cleared", 128'(bus1.done), 128'(0));
      chk("n1_busy_cycles", 128'(busy1_cnt), 128'(0));
      chk("n1_writes", 128'(we1_cnt), 128'(0));
      chk("n1_mem_addr", 128'(bus1.mem_addr), 128'(0));

      chk("queue_drained", 128'(q.size()), 128'(0));
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
